// File: rtl/usb_resume_gen.sv
// Full-speed USB device suspend tracker and remote-wakeup resume (K) generator.
// Watches the synchronised line state and drives K for the resume interval.
module usb_resume_gen #(
    parameter int CLK_PER_US   = 48,
    parameter int SUSPEND_US   = 3000,
    parameter int WAKE_IDLE_US = 5000,
    parameter int RESUME_US    = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic usb_p_rx,
    input  logic usb_n_rx,
    input  logic usb_reset,
    input  logic remote_wake_en,
    input  logic wake_req,
    output logic usb_p_tx,
    output logic usb_n_tx,
    output logic usb_tx_en,
    output logic suspended,
    output logic resume_active
);

    localparam int          PW          = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_US - 1);
    localparam logic [15:0] SUSPEND_T   = 16'(SUSPEND_US);
    localparam logic [15:0] WAKE_IDLE_T = 16'(WAKE_IDLE_US);
    localparam logic [15:0] RESUME_T    = 16'(RESUME_US);
    localparam logic [1:0]  LINE_J      = 2'b10;

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_SUSPENDED,
        ST_RESUME
    } state_t;

    logic [1:0]    rx_p0;
    logic [1:0]    rx_p1;
    logic          activity;
    logic [PW-1:0] presc;
    logic          us_tick;
    logic [15:0]   timer;
    logic          timer_clr;
    state_t        state;
    state_t        state_nx;
    logic          wake_pend;
    logic          wake_pend_nx;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage p0/p1: two-flop synchroniser for the asynchronous D+/D- pair
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_p0 <= 2'b00;
            rx_p1 <= 2'b00;
        end else begin
            rx_p0 <= {usb_p_rx, usb_n_rx};
            rx_p1 <= rx_p0;
        end
    end

    assign activity = (rx_p1 != LINE_J);
    assign us_tick  = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || us_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        state_nx     = state;
        wake_pend_nx = wake_pend;
        case (state)
            ST_ACTIVE: begin
                wake_pend_nx = 1'b0;
                // Activity in the threshold cycle keeps the device awake
                if (!activity && timer >= SUSPEND_T) begin
                    state_nx = ST_SUSPENDED;
                end
            end
            ST_SUSPENDED: begin
                if (activity) begin
                    state_nx     = ST_ACTIVE;
                    wake_pend_nx = 1'b0;
                end else begin
                    if (!remote_wake_en) begin
                        wake_pend_nx = 1'b0;
                    end else if (wake_req) begin
                        wake_pend_nx = 1'b1;
                    end
                    if (wake_pend && remote_wake_en && timer >= WAKE_IDLE_T) begin
                        state_nx     = ST_RESUME;
                        wake_pend_nx = 1'b0;
                    end
                end
            end
            ST_RESUME: begin
                wake_pend_nx = 1'b0;
                if (timer >= RESUME_T) begin
                    state_nx = ST_ACTIVE;
                end
            end
            default: begin
                state_nx     = ST_ACTIVE;
                wake_pend_nx = 1'b0;
            end
        endcase
        if (usb_reset) begin
            state_nx     = ST_ACTIVE;
            wake_pend_nx = 1'b0;
        end
    end

    // Our own K drive is not seen as activity, so RESUME ignores the receiver
    assign timer_clr = (state_nx != state) || usb_reset ||
                       (activity && state != ST_RESUME);

    always_ff @(posedge clk) begin
        if (!rst_n || timer_clr) begin
            timer <= '0;
        end else if (us_tick) begin
            timer <= sat_inc(timer);
        end
    end

    // Outputs registered from next state so they track the state register exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_ACTIVE;
            wake_pend     <= 1'b0;
            suspended     <= 1'b0;
            resume_active <= 1'b0;
            usb_tx_en     <= 1'b0;
            usb_p_tx      <= 1'b0;
            usb_n_tx      <= 1'b0;
        end else begin
            state         <= state_nx;
            wake_pend     <= wake_pend_nx;
            suspended     <= (state_nx == ST_SUSPENDED);
            resume_active <= (state_nx == ST_RESUME);
            usb_tx_en     <= (state_nx == ST_RESUME);
            usb_p_tx      <= 1'b0;
            usb_n_tx      <= (state_nx == ST_RESUME);
        end
    end

endmodule

// File: tb/tb_usb_resume_gen.sv
// Directed bench for usb_resume_gen: vector table for suspend/wake gating,
// hand sequences for resume timing, bus-reset abort and reset mid-resume.
module tb_usb_resume_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic usb_p_rx;
    logic usb_n_rx;
    logic usb_reset;
    logic remote_wake_en;
    logic wake_req;
    logic usb_p_tx;
    logic usb_n_tx;
    logic usb_tx_en;
    logic suspended;
    logic resume_active;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] J = 2'b10;
    localparam logic [1:0] K = 2'b01;
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_SUSP = 5'b10000;
    localparam logic [4:0] O_RES  = 5'b01011;

    usb_resume_gen #(
        .CLK_PER_US  (4),
        .SUSPEND_US  (30),
        .WAKE_IDLE_US(50),
        .RESUME_US   (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .usb_p_rx      (usb_p_rx),
        .usb_n_rx      (usb_n_rx),
        .usb_reset     (usb_reset),
        .remote_wake_en(remote_wake_en),
        .wake_req      (wake_req),
        .usb_p_tx      (usb_p_tx),
        .usb_n_tx      (usb_n_tx),
        .usb_tx_en     (usb_tx_en),
        .suspended     (suspended),
        .resume_active (resume_active)
    );

    always #5 clk = ~clk;

    // {suspended, tx_en, p_tx, n_tx, resume_active}
    function automatic logic [4:0] outs();
        return {suspended, usb_tx_en, usb_p_tx, usb_n_tx, resume_active};
    endfunction

    typedef struct {
        logic       rst_n;
        logic [1:0] line;
        logic       bus_rst;
        logic       rwe;
        logic       wreq;
        int         cycles;
        logic [4:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [1:0] l, input logic br,
                       input logic rw, input logic wr, input int c, input logic [4:0] e);
        vec_t v;
        v.rst_n = r; v.line = l; v.bus_rst = br; v.rwe = rw; v.wreq = wr;
        v.cycles = c; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: outputs {susp,tx_en,p,n,res}=%05b, required %05b", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int v, input int lo, input int hi);
        total++;
        if (v < lo || v > hi) begin
            bad++;
            $display("FAIL %s: got %0d cycles, required %0d..%0d", nm, v, lo, hi);
        end
    endtask

    // One K cycle to wake up, then idle J until suspend is reported again
    task automatic go_suspend(input string nm);
        int n = 0;
        {usb_p_rx, usb_n_rx} = K;
        @(negedge clk);
        {usb_p_rx, usb_n_rx} = J;
        while (suspended && n < 5) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!suspended && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!suspended) begin
            bad++;
            $display("FAIL %s: suspended=%0b after %0d cycles, required 1", nm, suspended, n);
        end
    endtask

    task automatic wait_tx(input string nm, input logic lvl, input int lim, inout int n);
        while (usb_tx_en !== lvl && n < lim) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (usb_tx_en !== lvl) begin
            bad++;
            $display("FAIL %s: usb_tx_en=%0b after %0d cycles, required %0b", nm, usb_tx_en, n, lvl);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; {usb_p_rx, usb_n_rx} = J; usb_reset = 1'b0;
        remote_wake_en = 1'b0; wake_req = 1'b0;

        // reset state
        add(0, J, 0, 0, 0, 3,   O_IDLE);
        // 29 us of J keeps ACTIVE, 30 us suspends
        add(1, K, 0, 0, 0, 1,   O_IDLE);
        add(1, J, 0, 0, 0, 117, O_IDLE);
        add(1, J, 0, 0, 0, 6,   O_SUSP);
        // K wakes after exactly two sync cycles, then re-suspends
        add(1, K, 0, 0, 0, 1,   O_SUSP);
        add(1, J, 0, 0, 0, 1,   O_SUSP);
        add(1, J, 0, 0, 0, 1,   O_IDLE);
        add(1, J, 0, 0, 0, 115, O_IDLE);
        add(1, J, 0, 0, 0, 6,   O_SUSP);
        // wake_req with remote wakeup disabled is never latched
        add(1, J, 0, 0, 1, 1,   O_SUSP);
        add(1, J, 0, 0, 0, 300, O_SUSP);
        add(1, J, 0, 1, 0, 1,   O_SUSP);
        add(1, J, 0, 1, 0, 300, O_SUSP);
        // pending request dropped when remote wakeup is withdrawn
        add(1, K, 0, 1, 0, 1,   O_SUSP);
        add(1, J, 0, 1, 0, 1,   O_SUSP);
        add(1, J, 0, 1, 0, 1,   O_IDLE);
        add(1, J, 0, 1, 0, 122, O_SUSP);
        add(1, J, 0, 1, 1, 1,   O_SUSP);
        add(1, J, 0, 1, 0, 20,  O_SUSP);
        add(1, J, 0, 0, 0, 1,   O_SUSP);
        add(1, J, 0, 1, 0, 300, O_SUSP);
        // wake_req while ACTIVE is ignored after the later suspend
        add(1, K, 0, 1, 0, 1,   O_SUSP);
        add(1, J, 0, 1, 0, 1,   O_SUSP);
        add(1, J, 0, 1, 0, 1,   O_IDLE);
        add(1, J, 0, 1, 1, 1,   O_IDLE);
        add(1, J, 0, 1, 0, 130, O_SUSP);
        add(1, J, 0, 1, 0, 300, O_SUSP);

        foreach (vq[i]) begin
            rst_n = vq[i].rst_n;
            {usb_p_rx, usb_n_rx} = vq[i].line;
            usb_reset = vq[i].bus_rst;
            remote_wake_en = vq[i].rwe;
            wake_req = vq[i].wreq;
            repeat (vq[i].cycles) @(negedge clk);
            chk($sformatf("vec%0d", i), outs(), vq[i].exp);
        end
        wake_req = 1'b0;

        // resume waits for 50 us idle in suspend, then drives K for 100 us
        remote_wake_en = 1'b0;
        go_suspend("t3 suspend");
        repeat (40) @(negedge clk);
        remote_wake_en = 1'b1; wake_req = 1'b1;
        @(negedge clk);
        wake_req = 1'b0;
        n = 41;
        wait_tx("t3 rise", 1'b1, 400, n);
        chk_range("t3 idle time", n, 198, 201);
        chk("t3 drive", outs(), O_RES);
        n = 0;
        wait_tx("t3 fall", 1'b0, 500, n);
        chk_range("t3 resume time", n, 398, 401);
        chk("t3 release", outs(), O_IDLE);

        // bus reset 40 us into resume aborts the drive next cycle
        go_suspend("t5 suspend");
        wake_req = 1'b1;
        @(negedge clk);
        wake_req = 1'b0;
        n = 0;
        wait_tx("t5 rise", 1'b1, 300, n);
        repeat (160) @(negedge clk);
        chk("t5 mid", outs(), O_RES);
        usb_reset = 1'b1;
        @(negedge clk);
        chk("t5 abort", outs(), O_IDLE);
        usb_reset = 1'b0;

        // rst_n mid-resume releases the bus and forgets the request
        go_suspend("t6 suspend");
        wake_req = 1'b1;
        @(negedge clk);
        wake_req = 1'b0;
        n = 0;
        wait_tx("t6 rise", 1'b1, 300, n);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6 reset", outs(), O_IDLE);
        rst_n = 1'b1;
        repeat (500) @(negedge clk);
        chk("t6 no redrive", outs(), O_SUSP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
